// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer
// Function : Bit-serial WIDTH-bit adder/subtractor. One 1-bit adder cell is
//            reused once per clock, LSB first. Operands arrive on a
//            valid/ready request channel; sum, carry and signed overflow
//            leave on a valid/ready result channel.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_out_r;
  logic             overflow_r;

  // Single 1-bit adder cell: two half-add stages plus carry OR.
  logic             half_sum;
  logic             half_gen;
  logic             sum_bit;
  logic             prop_gen;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  assign half_sum   = a_sh[0] ^ b_sh[0];
  assign half_gen   = a_sh[0] & b_sh[0];
  assign sum_bit    = half_sum ^ carry_r;
  assign prop_gen   = half_sum & carry_r;
  assign carry_next = half_gen | prop_gen;

  // New sum bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
  assign res_next = (res_sh >> 1) | ({{(WIDTH-1){1'b0}}, sum_bit} << (WIDTH - 1));
  assign last_bit = (cnt == LAST_BIT);

  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; unused encoding recovers to IDLE.
  always_comb begin
    state_next = IDLE;
    req_ready  = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready  = 1'b1;
        state_next = req_valid ? RUN : IDLE;
      end
      RUN: begin
        busy       = 1'b1;
        state_next = last_bit ? DONE : RUN;
      end
      DONE: begin
        busy       = 1'b1;
        res_valid  = 1'b1;
        state_next = res_ready ? IDLE : DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, serial datapath and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      cnt         <= '0;
      carry_r     <= 1'b0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            a_sh    <= op_a;
            b_sh    <= sub ? ~op_b : op_b;
            carry_r <= sub;
            cnt     <= '0;
            res_sh  <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_next;
          carry_r <= carry_next;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            // carry_r still holds the carry into the MSB on this edge.
            result_r    <= res_next;
            carry_out_r <= carry_next;
            overflow_r  <= carry_r ^ carry_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sequencer
// Function : Self-checking bench for serial_add_sequencer (WIDTH=8): vector
//            table, directed backpressure / mid-run reset sequences and
//            randomised transactions checked through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] r;
    logic       c;
    logic       v;
  } vec_t;

  exp_t sb_q[$];

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic with sign-rule overflow.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [8:0] full;
    exp_t       e;
    if (s) full = {1'b0, a} - {1'b0, b};
    else   full = {1'b0, a} + {1'b0, b};
    e.r = full[7:0];
    // For subtraction the carry is "no borrow".
    e.c = s ? (a >= b) : full[8];
    if (s) e.v = (a[7] != b[7]) && (e.r[7] != a[7]);
    else   e.v = (a[7] == b[7]) && (e.r[7] != a[7]);
    return e;
  endfunction

  // One full transaction; expectation is pushed on accept and popped on res_valid.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input exp_t e_in, input int stall, input bit noise);
    exp_t e;
    int   lat;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub  = s;
    sb_q.push_back(e_in);
    @(negedge clk);
    req_valid = noise ? 1'($urandom) : 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    sub  = 1'($urandom);
    check("busy_after_accept", {busy, req_ready, res_valid}, 3'b100);
    lat = 0;
    while (!res_valid && lat < WIDTH + 4) begin
      if (noise) res_ready = 1'($urandom);
      @(negedge clk);
      lat++;
      if (busy && req_ready) check("req_ready_while_busy", req_ready, 0);
    end
    check("latency", lat, WIDTH);
    if (!res_valid) begin
      // Recover from a stuck sequencer so the run still reaches the summary.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      req_valid = 1'b0;
      res_ready = 1'b0;
      return;
    end
    e = sb_q.pop_front();
    check("result", result, e.r);
    check("carry_out", carry_out, e.c);
    check("overflow", overflow, e.v);
    res_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        req_valid = 1'($urandom);
        op_a = 8'($urandom);
      end
      @(negedge clk);
      check("hold_valid", {res_valid, req_ready, busy}, 3'b101);
      check("hold_result", {result, carry_out, overflow}, {e.r, e.c, e.v});
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_after_handshake", {res_valid, busy, req_ready}, 3'b001);
    check("retain_result", {result, carry_out, overflow}, {e.r, e.c, e.v});
  endtask

  initial begin
    vec_t tbl[5];
    exp_t e;
    tbl[0] = '{a: 8'h5A, b: 8'h3C, s: 1'b0, r: 8'h96, c: 1'b0, v: 1'b1};
    tbl[1] = '{a: 8'hFF, b: 8'h01, s: 1'b0, r: 8'h00, c: 1'b1, v: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h00, s: 1'b0, r: 8'h00, c: 1'b0, v: 1'b0};
    tbl[3] = '{a: 8'h10, b: 8'h20, s: 1'b1, r: 8'hF0, c: 1'b0, v: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h01, s: 1'b1, r: 8'h7F, c: 1'b1, v: 1'b1};

    rst = 1'b1;
    req_valid = 1'b0;
    res_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    sub  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_handshake", {req_ready, busy, res_valid}, 3'b100);
    check("reset_outputs", {result, carry_out, overflow}, 10'h0);
    rst = 1'b0;

    // Vector table, immediate result acceptance.
    for (int i = 0; i < 5; i++) begin
      e = '{r: tbl[i].r, c: tbl[i].c, v: tbl[i].v};
      run_txn(tbl[i].a, tbl[i].b, tbl[i].s, e, 0, 1'b0);
    end

    // Backpressure: five stalled DONE cycles with request-side noise.
    e = '{r: 8'h96, c: 1'b0, v: 1'b1};
    run_txn(8'h5A, 8'h3C, 1'b0, e, 5, 1'b1);

    // Reset asserted so it is sampled on the third RUN edge.
    @(negedge clk);
    req_valid = 1'b1;
    op_a = 8'h5A;
    op_b = 8'h3C;
    sub  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_reset_state", {req_ready, busy, res_valid}, 3'b100);
    check("midrun_reset_result", {result, carry_out, overflow}, 10'h0);
    e = '{r: 8'h03, c: 1'b0, v: 1'b0};
    run_txn(8'h01, 8'h02, 1'b0, e, 0, 1'b0);

    // Randomised transactions with random result stalls.
    for (int n = 0; n < 200; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run_txn(ra, rb, rs, model(ra, rb, rs), int'($urandom_range(0, 3)), 1'b1);
    end

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit in case a wait is never satisfied.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
